// File: rtl/periph_arbiter.sv
// periph_arbiter
//   Two-port round-robin arbiter and access sequencer for the 4-register peripheral window.
//   Requester 0 (CPU data port) and requester 1 (DMA/debug port) are serialised; each access
//   holds the peripheral select for WAIT_CYCLES+1 cycles, then pulses the owner's ready.
//
// Ports
//   clk_i, reset_i            clock, asynchronous active-high reset
//   rN_req_i                  access request, held until rN_ready_o
//   rN_addr_i                 byte address, bits [3:2] select the register
//   rN_we_i                   byte write enables, 4'b0000 = read
//   rN_wdata_i                write data
//   rN_ready_o                one-cycle completion pulse
//   rN_rdata_o                read data, held until the next read by that requester completes
//   ce_o, pwe_o               peripheral chip enable / write enable
//   addr_o, pwdata_o          peripheral register index / write data
//   prdata_i                  peripheral read data
//   busy_o                    FSM not idle
//   owner_o                   requester currently or most recently granted

module periph_arbiter #(
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk_i,
   input  logic        reset_i,

   input  logic        r0_req_i,
   input  logic [31:0] r0_addr_i,
   input  logic [3:0]  r0_we_i,
   input  logic [31:0] r0_wdata_i,
   output logic        r0_ready_o,
   output logic [31:0] r0_rdata_o,

   input  logic        r1_req_i,
   input  logic [31:0] r1_addr_i,
   input  logic [3:0]  r1_we_i,
   input  logic [31:0] r1_wdata_i,
   output logic        r1_ready_o,
   output logic [31:0] r1_rdata_o,

   output logic        ce_o,
   output logic        pwe_o,
   output logic [1:0]  addr_o,
   output logic [31:0] pwdata_o,
   input  logic [31:0] prdata_i,

   output logic        busy_o,
   output logic        owner_o
);

   localparam logic [7:0] WaitInit = 8'(WAIT_CYCLES);

   typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        owner_q, owner_d;
   logic        last_owner_q, last_owner_d;
   logic [1:0]  addr_q, addr_d;
   logic [3:0]  we_q, we_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] r0_rdata_q, r0_rdata_d;
   logic [31:0] r1_rdata_q, r1_rdata_d;

   logic        req_any;
   logic        gnt;

   // Only the register index bits of the byte address matter.
   logic        unused_addr;
   assign unused_addr = ^{r0_addr_i[31:4], r0_addr_i[1:0], r1_addr_i[31:4], r1_addr_i[1:0]};

   // On a tie the requester that did not go last wins; otherwise the lone requester wins.
   assign req_any = r0_req_i | r1_req_i;
   assign gnt     = (r0_req_i & r1_req_i) ? ~last_owner_q : r1_req_i;

   // State register
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (req_any) state_d = StAccess;
         StAccess: if (cnt_q == 8'd0) state_d = StDone;
         StDone:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Outputs, decoded from state and captured registers only
   always_comb begin
      ce_o       = (state_q == StAccess);
      pwe_o      = (state_q == StAccess) && (we_q != 4'b0000);
      addr_o     = addr_q;
      pwdata_o   = wdata_q;
      r0_ready_o = (state_q == StDone) && !owner_q;
      r1_ready_o = (state_q == StDone) && owner_q;
      r0_rdata_o = r0_rdata_q;
      r1_rdata_o = r1_rdata_q;
      busy_o     = (state_q != StIdle);
      owner_o    = owner_q;
   end

   // Datapath next-state
   always_comb begin
      cnt_d        = cnt_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      addr_d       = addr_q;
      we_d         = we_q;
      wdata_d      = wdata_q;
      r0_rdata_d   = r0_rdata_q;
      r1_rdata_d   = r1_rdata_q;
      unique case (state_q)
         StIdle: begin
            if (req_any) begin
               owner_d = gnt;
               addr_d  = gnt ? r1_addr_i[3:2] : r0_addr_i[3:2];
               we_d    = gnt ? r1_we_i : r0_we_i;
               wdata_d = gnt ? r1_wdata_i : r0_wdata_i;
               cnt_d   = WaitInit;
            end
         end
         StAccess: begin
            if (cnt_q == 8'd0) begin
               // Writes leave the owner's read-data register untouched.
               if (we_q == 4'b0000) begin
                  if (owner_q) begin
                     r1_rdata_d = prdata_i;
                  end else begin
                     r0_rdata_d = prdata_i;
                  end
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         StDone: begin
            last_owner_d = owner_q;
         end
         default: ;
      endcase
   end

   // Datapath registers; last_owner resets to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         cnt_q        <= 8'd0;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         addr_q       <= 2'b00;
         we_q         <= 4'b0000;
         wdata_q      <= 32'd0;
         r0_rdata_q   <= 32'd0;
         r1_rdata_q   <= 32'd0;
      end else begin
         cnt_q        <= cnt_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         addr_q       <= addr_d;
         we_q         <= we_d;
         wdata_q      <= wdata_d;
         r0_rdata_q   <= r0_rdata_d;
         r1_rdata_q   <= r1_rdata_d;
      end
   end

endmodule

// File: doc/periph_arbiter.md
# periph_arbiter

Two-port arbiter and access sequencer for the 4-register memory-mapped peripheral window (the region selected by address bit 9, registers indexed by address bits [3:2]). It sits between two bus masters, the CPU data port (requester 0) and a DMA/debug port (requester 1), and the peripheral. It serialises their accesses with round-robin priority and stretches each access by a fixed number of wait states. It drives the peripheral chip-enable, write-enable and register index, and returns read data with a one-cycle ready pulse.

## Interface
- WAIT_CYCLES, 2: extra ACCESS cycles beyond the first; legal range 0..255.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- r0_req  in  1  requester 0 access request; held until r0_ready.
- r0_addr  in  32  requester 0 byte address; only bits [3:2] are used.
- r0_we  in  4  requester 0 byte write enables; 4'b0000 = read.
- r0_wdata  in  32  requester 0 write data.
- r0_ready  out  1  one-cycle completion pulse for requester 0.
- r0_rdata  out  32  requester 0 read data; valid when r0_ready=1, held until its next read completes.
- r1_req, r1_addr, r1_we, r1_wdata, r1_ready, r1_rdata: identical definitions for requester 1.
- CE  out  1  peripheral chip enable.
- PWE  out  1  peripheral write enable.
- addr  out  2  peripheral register index.
- pwdata  out  32  peripheral write data.
- prdata  in  32  peripheral read data.
- busy  out  1  high when the FSM is not in IDLE.
- owner  out  1  index of the requester currently or most recently granted.

## Operation
- The FSM has three states: IDLE, ACCESS and DONE. Reset forces IDLE.
- IDLE:
  - r0_req and r1_req are sampled only in this state.
  - If any request is pending, the arbiter picks a winner. On a tie, the winner is the requester that is not last_owner.
  - The winner's addr[3:2], we and wdata are captured into internal registers, and owner is set to the winner.
  - Wait counter is loaded with WAIT_CYCLES; next state is ACCESS.
- ACCESS:
  - CE=1. addr, pwdata and PWE (= |captured_we) come from the captured registers and stay stable for the whole state.
  - The counter decrements each cycle. In the cycle where the counter equals 0, prdata is sampled and the next state is DONE.
  - On a read, the sampled prdata goes into the owner's rdata register. On a write, that register is not changed.
- DONE:
  - CE=0, PWE=0. The owner's ready pulses for one cycle.
  - last_owner is updated to owner. Next state is IDLE.
- A requester must deassert req on the clock edge where its ready is high. If req is still high when the FSM returns to IDLE, a new transaction starts.
- Requests arriving while busy wait in their port. They are never dropped.
- The non-owner's ready, and its rdata register, are never disturbed.

## Timing
- Reset values:
  - CE=0, PWE=0, addr=0, pwdata=0.
  - r0_ready=r1_ready=0, r0_rdata=r1_rdata=0.
  - busy=0, owner=0.
  - last_owner=1, so requester 0 wins the first tie.
- Latency:
  - req first seen in IDLE at cycle 0.
  - CE high in cycles 1..WAIT_CYCLES+1.
  - ready high in cycle WAIT_CYCLES+2.
  - Next grant decision in cycle WAIT_CYCLES+3.
- Sustained throughput: one access per WAIT_CYCLES+3 cycles.
- With WAIT_CYCLES=0, ACCESS lasts exactly one cycle.
- Outputs CE, PWE, addr, pwdata, ready and rdata are all registered or decoded from state only. No input-to-output combinational path exists.
- Reset asserted mid-transaction:
  - Immediate return to reset values. The transaction is abandoned with no ready pulse.
  - After reset releases, the first access restarts from IDLE.

## Test plan
- Single read, WAIT_CYCLES=2: prdata=32'hDEADBEEF; r0 requests addr=32'h208 at cycle 0.
  - Required: CE=1 and addr=2'b10 in cycles 1-3, PWE=0.
  - Required: r0_ready=1 with r0_rdata=32'hDEADBEEF at cycle 4.
- Write from requester 1: r1 requests addr=32'h20C, we=4'hF, wdata=32'h12345678.
  - Required: PWE=1, addr=2'b11, pwdata=32'h12345678 for all 3 ACCESS cycles.
  - Required: r1_ready at cycle 4; r1_rdata unchanged.
- Contention: r0 and r1 both request continuously after reset, each re-asserting one cycle after its ready.
  - Required: grants alternate 0,1,0,1.
  - Required: each ready is a single cycle, 5 cycles apart, never both ready in the same cycle.
- Reset mid-access: assert reset during the 2nd ACCESS cycle of an r0 read.
  - Required: CE, PWE, busy and r0_ready go to 0 immediately; no ready pulse ever appears for that read.
  - Required: an r0 read issued after reset completes with normal 4-cycle latency.
- WAIT_CYCLES=0: r0 read at addr=32'h200, prdata=32'hA5A5A5A5.
  - Required: CE high for exactly one cycle (cycle 1).
  - Required: r0_ready at cycle 2 with r0_rdata=32'hA5A5A5A5.
- Stale req: r0 holds req high one cycle past ready.
  - Required: a second identical access starts, i.e. CE rises again at the cycle after the return to IDLE.
